// File: rtl/inflation_window_max.sv
// inflation_window_max: computes the saturated maximum of (cell*weight)>>SHIFT over one
// streamed kernel window and emits a single result per window.
module inflation_window_max #(
    parameter int KERNEL_SIZE  = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BUS_WIDTH    = 32,
    parameter int OUT_WIDTH    = 8,
    parameter int SHIFT        = 8
) (
    input  logic                                              clk,
    input  logic                                              rstn,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]   weights_in,
    input  logic                                              weights_loading,
    input  logic [BUS_WIDTH-1:0]                              s_axis_tdata,
    input  logic                                              s_axis_tvalid,
    input  logic                                              s_axis_tlast,
    output logic                                              s_axis_tready,
    output logic [OUT_WIDTH-1:0]                              m_axis_tdata,
    output logic                                              m_axis_tvalid,
    input  logic                                              m_axis_tready,
    output logic                                              framing_error,
    output logic [15:0]                                       windows_done
);
    localparam int N         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int LANES     = BUS_WIDTH / WEIGHT_WIDTH;
    localparam int NUM_BEATS = (N + LANES - 1) / LANES;
    localparam int CW        = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
    localparam int PW        = 2 * WEIGHT_WIDTH;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);
    localparam logic [PW-1:0] OUT_MAX   = PW'({OUT_WIDTH{1'b1}});

    typedef enum logic [1:0] {WAIT_W, ACCUM, OUTPUT} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           beat;
    logic [PW-1:0]           run_max, beat_max, acc_max;
    logic [WEIGHT_WIDTH-1:0] wt [NUM_BEATS][LANES];
    logic [PW-1:0]           lane_val [LANES];
    logic                    accept, out_hs, abort;

    // Weights regrouped in beat/lane order; padding cells beyond N get weight 0.
    for (genvar k = 0; k < NUM_BEATS; k++) begin : g_beat
        for (genvar j = 0; j < LANES; j++) begin : g_wt
            if (k * LANES + j < N) begin : g_real
                assign wt[k][j] = weights_in[WEIGHT_WIDTH*N-1-(k*LANES+j)*WEIGHT_WIDTH -: WEIGHT_WIDTH];
            end else begin : g_pad
                assign wt[k][j] = '0;
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_val[j] = (PW'(wt[beat][j]) * PW'(s_axis_tdata[BUS_WIDTH-1-j*WEIGHT_WIDTH -: WEIGHT_WIDTH])) >> SHIFT;
    end

    always_comb begin
        beat_max = '0;
        for (int j = 0; j < LANES; j++)
            beat_max = lane_val[j] > beat_max ? lane_val[j] : beat_max;
    end

    assign acc_max = beat_max > run_max ? beat_max : run_max;
    assign accept  = state == ACCUM && s_axis_tvalid && !weights_loading;
    assign abort   = state == ACCUM && weights_loading;
    assign out_hs  = state == OUTPUT && m_axis_tready;

    always_comb begin
        state_nx      = state;
        s_axis_tready = state == ACCUM;
        m_axis_tvalid = state == OUTPUT;
        m_axis_tdata  = state != OUTPUT ? '0 :
                        run_max > OUT_MAX ? {OUT_WIDTH{1'b1}} : run_max[OUT_WIDTH-1:0];
        unique case (state)
            WAIT_W:  state_nx = weights_loading ? WAIT_W : ACCUM;
            ACCUM:   state_nx = weights_loading ? WAIT_W : (accept && beat == LAST_BEAT) ? OUTPUT : ACCUM;
            OUTPUT:  state_nx = !m_axis_tready ? OUTPUT : weights_loading ? WAIT_W : ACCUM;
            default: state_nx = WAIT_W;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= WAIT_W;
            beat          <= '0;
            run_max       <= '0;
            framing_error <= 1'b0;
            windows_done  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                run_max <= acc_max;
                beat    <= beat == LAST_BEAT ? '0 : beat + CW'(1);
                if (s_axis_tlast != (beat == LAST_BEAT))
                    framing_error <= 1'b1;
            end else if (abort || out_hs) begin
                run_max <= '0;
                beat    <= '0;
            end
            if (out_hs)
                windows_done <= windows_done + 16'd1;
        end
    end
endmodule

// File: tb/tb_inflation_window_max.sv
// tb_inflation_window_max: directed checks of a 3x3 window (SHIFT=8) plus a SHIFT=0 twin
// running in lockstep to exercise output saturation.
module tb_inflation_window_max;
    logic        clk = 0, rstn = 0, loading = 1, s_valid = 0, s_last = 0, m_ready = 0;
    logic [71:0] w = '0;
    logic [71:0] w0 = {8'h10, 64'h0};
    logic [31:0] s_data = '0;
    logic        s_ready, m_valid, ferr, z_ready, z_valid, z_ferr;
    logic [7:0]  m_data, z_data;
    logic [15:0] wd, z_wd;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    inflation_window_max #(.KERNEL_SIZE(3), .WEIGHT_WIDTH(8), .BUS_WIDTH(32), .OUT_WIDTH(8), .SHIFT(8)) dut (
        .clk(clk), .rstn(rstn), .weights_in(w), .weights_loading(loading),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .framing_error(ferr), .windows_done(wd));

    inflation_window_max #(.KERNEL_SIZE(3), .WEIGHT_WIDTH(8), .BUS_WIDTH(32), .OUT_WIDTH(8), .SHIFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .weights_in(w0), .weights_loading(loading),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(z_ready),
        .m_axis_tdata(z_data), .m_axis_tvalid(z_valid), .m_axis_tready(m_ready),
        .framing_error(z_ferr), .windows_done(z_wd));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setw(input int i, input logic [7:0] v);
        w[71-8*i -: 8] = v;
    endtask

    // Presents one beat, waits (bounded) for ready, and retires it on the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        s_data = d; s_valid = 1; s_last = l;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready", 32'(s_ready), 1);
        @(posedge clk);
        #1 s_valid = 0; s_last = 0;
    endtask

    task automatic handshake();
        @(negedge clk);
        m_ready = 1;
        @(posedge clk);
        #1 m_ready = 0;
    endtask

    initial begin
        // Reset and kernel-load gating
        @(negedge clk);
        chk("rst_sready", 32'(s_ready), 0);
        chk("rst_mvalid", 32'(m_valid), 0);
        chk("rst_mdata", 32'(m_data), 0);
        chk("rst_ferr", 32'(ferr), 0);
        chk("rst_wd", 32'(wd), 0);
        rstn = 1;
        repeat (2) @(negedge clk);
        chk("loading_sready", 32'(s_ready), 0);
        loading = 0;
        @(negedge clk);
        chk("load_done_sready", 32'(s_ready), 1);

        // All weights 0xFF, cell 4 = 0x80 -> 0x7F80>>8 = 0x7F
        w = {9{8'hFF}};
        send(32'h0, 0);
        send(32'h8000_0000, 0);
        send(32'h0, 1);
        @(negedge clk);
        chk("t2_mvalid", 32'(m_valid), 1);
        chk("t2_mdata", 32'(m_data), 32'h7F);
        chk("t2_sready", 32'(s_ready), 0);
        chk("t2_ferr", 32'(ferr), 0);
        chk("t2_z_mdata", 32'(z_data), 0);
        handshake();
        @(negedge clk);
        chk("t2_wd", 32'(wd), 1);
        chk("t2_mvalid_low", 32'(m_valid), 0);
        chk("t2_sready_back", 32'(s_ready), 1);

        // Only weight 8 nonzero; padding lanes full, cell 8 = 0 -> 0
        w = '0;
        setw(8, 8'hFF);
        send(32'h01FF_FFFF, 0);
        send(32'hFFFF_FFFF, 0);
        send(32'h00FF_FFFF, 1);
        @(negedge clk);
        chk("t3_mdata", 32'(m_data), 0);
        chk("t3_mvalid", 32'(m_valid), 1);
        chk("t3_z_unsat", 32'(z_data), 32'h10);
        handshake();
        @(negedge clk);
        chk("t3_wd", 32'(wd), 2);

        // Mixed: 0x40*0x10>>8=4, 0xC0*0xC8>>8=0x96, 0x80*0xFF>>8=0x7F -> 0x96; twin saturates 0x100
        w = '0;
        setw(0, 8'h40); setw(5, 8'hC0); setw(8, 8'h80);
        send(32'h1000_0000, 0);
        send(32'h00C8_0000, 0);
        send(32'hFF00_0000, 1);
        @(negedge clk);
        chk("t4_mdata", 32'(m_data), 32'h96);
        chk("t4_z_sat", 32'(z_data), 32'hFF);
        s_data = 32'h0; s_valid = 1; s_last = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_mvalid", 32'(m_valid), 1);
            chk("stall_mdata", 32'(m_data), 32'h96);
            chk("stall_sready", 32'(s_ready), 0);
        end
        handshake();
        @(negedge clk);
        s_valid = 0;
        chk("t5_wd", 32'(wd), 3);

        // Early tlast on beat 1: sticky error, result still after beat 2 (0xC0*0x10>>8 = 0x0C)
        send(32'h0, 0);
        send(32'h0010_0000, 1);
        @(negedge clk);
        chk("t6_ferr", 32'(ferr), 1);
        chk("t6_no_early_out", 32'(m_valid), 0);
        send(32'h0, 1);
        @(negedge clk);
        chk("t6_mdata", 32'(m_data), 32'h0C);
        handshake();
        @(negedge clk);
        chk("t6_wd", 32'(wd), 4);

        // Loading pulse after beat 1 discards the partial window
        send(32'hFF00_0000, 0);
        send(32'h00FF_0000, 0);
        @(negedge clk);
        loading = 1;
        @(negedge clk);
        chk("abort_sready", 32'(s_ready), 0);
        chk("abort_mvalid", 32'(m_valid), 0);
        loading = 0;
        @(negedge clk);
        chk("abort_resume", 32'(s_ready), 1);
        send(32'h0, 0);
        send(32'h0020_0000, 0);
        send(32'h0, 1);
        @(negedge clk);
        chk("fresh_mdata", 32'(m_data), 32'h18);
        chk("fresh_ferr_sticky", 32'(ferr), 1);
        handshake();
        @(negedge clk);
        chk("fresh_wd", 32'(wd), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
